commit_controller: RTL and testbench
====================================

Name: commit_controller

Overview:
- Retires completed instructions from the reservation buffer in program order, up to 2 per cycle.
- Drives the register-file write ports and frees the retired buffer entries.
- Serialises stores to data memory through a req/ack handshake.
- Sits between the reservation buffer and the register file / data-memory port, in parallel with dispatch.

Parameters:
- BUF_SIZE, 16, number of reservation-buffer entries (package value).
- BUF_SIZE_LOG, 4, log2(BUF_SIZE); entry tags are BUF_SIZE_LOG+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- entries_all  in  entry[BUF_SIZE]  current buffer contents.
- flush  in  1  branch-mispredict flush pulse.
- store_ack  in  1  data memory accepted the current store.
- commit_valid  out  1[2]  slot k retires an entry this cycle.
- commit_index  out  BUF_SIZE_LOG[2]  buffer index freed by slot k.
- reg_we  out  1[2]  register write enable, slot k.
- reg_waddr  out  5[2]  register write address, slot k.
- reg_wdata  out  32[2]  register write data, slot k.
- store_req  out  1  store request to data memory.
- store_addr  out  32  store address.
- store_data  out  32  store data.
- retired_count  out  32  total retired instructions.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- Age ordering:
  - Occupied entry: e_state != S_NOT_USED.
  - Oldest occupied entry: largest tag, unsigned compare. Second-oldest: next largest.
  - Ties do not occur; if they do, the lower index wins.
- Retire condition: an entry is retirable when e_state == S_EXECUTED.
- IDLE, oldest entry O retirable and not STORE:
  - Next cycle, slot 0 has commit_valid=1 and commit_index=O.
  - reg_we=1 iff O.Dest != 0; reg_waddr=O.Dest; reg_wdata=O.result.
- Slot 1:
  - Retires second-oldest entry S under the same rules, only if slot 0 retires and S is retirable non-STORE.
  - Never retires past a non-retirable or STORE entry (in-order).
  - Both slots writing the same Dest is legal; slot 1 wins in the register file.
- IDLE, oldest entry O retirable STORE:
  - Next cycle: store_req=1, store_addr=O.result, store_data=O.Vk. Latch O's index. Go to ST_WAIT.
  - No commits occur in that cycle.
- ST_WAIT:
  - Hold store_req, store_addr and store_data stable until store_ack is sampled 1.
  - On ack: next cycle store_req=0, slot 0 has commit_valid=1 with the latched index and reg_we=0. Return to IDLE.
  - Ack in the same cycle the request first rises is legal; it completes as above.
- IDLE, store_ack=1 with no request: ignored.
- commit_valid and reg_we are single-cycle pulses; the buffer clears the entry on that edge.
- The controller never re-evaluates an entry in the cycle its commit is visible; the buffer guarantees the freed state by the following cycle.
- Flush:
  - In IDLE: suppresses commits evaluated that cycle. Outputs are 0 next cycle.
  - In ST_WAIT: the store is non-speculative, so the FSM stays in ST_WAIT and completes the store; flush is ignored.
- Empty buffer: no commits, FSM stays in IDLE.
- retired_count:
  - Adds the number of commit_valid slots asserted (0, 1 or 2) each cycle.
  - Wraps modulo 2^32.
  - Cleared only by rst.
- rst mid-store: store_req drops next cycle, the latched index is discarded, FSM goes to IDLE. No commit is issued for the in-flight store.

Test Plan:
- Reset with rst=1 for 2 cycles, entries arbitrary -> all outputs 0 and FSM in IDLE.
- Entry 3 (tag 15, EXECUTED, ALU, Dest=5, result=0x1234) and entry 7 (tag 14, EXECUTED, Dest=6, result=0x55) -> next cycle commit_valid={1,1}, commit_index={3,7}, reg_waddr={5,6}, reg_wdata={0x1234,0x55}; retired_count=2.
- Entry 2 (tag 15, NOT_EXECUTED) and entry 4 (tag 14, EXECUTED) -> no commits until entry 2 becomes EXECUTED, then both retire together.
- Oldest entry 9 (tag 15, EXECUTED STORE, result=0x100, Vk=0xDEAD) -> store_req=1, addr=0x100, data=0xDEAD; hold with ack=0 for 3 cycles; ack=1 -> next cycle store_req=0, commit_valid[0]=1, commit_index[0]=9, reg_we[0]=0.
- Entry with Dest=0 executed and oldest -> commit_valid=1, reg_we=0.
- Flush asserted in ST_WAIT, then ack -> the store still commits. Flush in IDLE with two retirable entries -> no commit that cycle; they retire next cycle if still present.

Source files
------------

// File: rtl/commit_controller.sv
// In-order retirement: up to two buffer entries per cycle, with
// stores sent to data memory one at a time over a req/ack handshake.
package commit_pkg;
  localparam int BUF_SIZE     = 16;
  localparam int BUF_SIZE_LOG = 4;
  localparam int TAG_W        = BUF_SIZE_LOG + 1;

  typedef enum logic [1:0] {
    S_NOT_USED,
    S_NOT_EXECUTED,
    S_EXECUTED
  } e_state_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH
  } op_t;

  typedef struct packed {
    e_state_t         e_state;
    logic [TAG_W-1:0] tag;
    op_t              op;
    logic [4:0]       dest;
    logic [31:0]      result;
    logic [31:0]      vk;
  } entry_t;
endpackage

module commit_controller
  import commit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  entry_t                       entries_all [BUF_SIZE],
  input  logic                         flush,
  input  logic                         store_ack,
  output logic [1:0]                   commit_valid,
  output logic [1:0][BUF_SIZE_LOG-1:0] commit_index,
  output logic [1:0]                   reg_we,
  output logic [1:0][4:0]              reg_waddr,
  output logic [1:0][31:0]             reg_wdata,
  output logic                         store_req,
  output logic [31:0]                  store_addr,
  output logic [31:0]                  store_data,
  output logic [31:0]                  retired_count
);

  typedef enum logic {IDLE, ST_WAIT} state_t;

  state_t                       state_q, state_d;
  logic [BUF_SIZE_LOG-1:0]      st_idx_q, st_idx_d;
  logic [1:0]                   commit_valid_q, commit_valid_d;
  logic [1:0][BUF_SIZE_LOG-1:0] commit_index_q, commit_index_d;
  logic [1:0]                   reg_we_q, reg_we_d;
  logic [1:0][4:0]              reg_waddr_q, reg_waddr_d;
  logic [1:0][31:0]             reg_wdata_q, reg_wdata_d;
  logic                         store_req_q, store_req_d;
  logic [31:0]                  store_addr_q, store_addr_d;
  logic [31:0]                  store_data_q, store_data_d;
  logic [31:0]                  retired_count_q, retired_count_d;

  logic [BUF_SIZE-1:0]     live;
  logic                    old_hit, sec_hit;
  logic [BUF_SIZE_LOG-1:0] old_idx, sec_idx;
  logic [TAG_W-1:0]        old_tag, sec_tag;
  entry_t                  old_e, sec_e;
  logic                    old_ok, sec_ok;

  // Entries whose commit is visible now are still in the buffer; skip them.
  always_comb begin
    live = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      live[i] = entries_all[i].e_state != S_NOT_USED;
      for (int k = 0; k < 2; k++) begin
        if (commit_valid_q[k] &&
            commit_index_q[k] == BUF_SIZE_LOG'(i))
          live[i] = 1'b0;
      end
    end
  end

  always_comb begin
    old_hit = 1'b0;
    old_idx = '0;
    old_tag = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (live[i] &&
          (!old_hit || entries_all[i].tag > old_tag)) begin
        old_hit = 1'b1;
        old_idx = BUF_SIZE_LOG'(i);
        old_tag = entries_all[i].tag;
      end
    end
    sec_hit = 1'b0;
    sec_idx = '0;
    sec_tag = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (live[i] && old_idx != BUF_SIZE_LOG'(i) &&
          (!sec_hit || entries_all[i].tag > sec_tag)) begin
        sec_hit = 1'b1;
        sec_idx = BUF_SIZE_LOG'(i);
        sec_tag = entries_all[i].tag;
      end
    end
  end

  assign old_e  = entries_all[old_idx];
  assign sec_e  = entries_all[sec_idx];
  assign old_ok = old_hit && old_e.e_state == S_EXECUTED;
  assign sec_ok = sec_hit && sec_e.e_state == S_EXECUTED &&
                  sec_e.op != OP_STORE;

  always_comb begin
    state_d        = state_q;
    st_idx_d       = st_idx_q;
    commit_valid_d = '0;
    commit_index_d = '0;
    reg_we_d       = '0;
    reg_waddr_d    = '0;
    reg_wdata_d    = '0;
    store_req_d    = 1'b0;
    store_addr_d   = '0;
    store_data_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!flush && old_ok) begin
          if (old_e.op == OP_STORE) begin
            store_req_d  = 1'b1;
            store_addr_d = old_e.result;
            store_data_d = old_e.vk;
            st_idx_d     = old_idx;
            state_d      = ST_WAIT;
          end else begin
            commit_valid_d[0] = 1'b1;
            commit_index_d[0] = old_idx;
            reg_we_d[0]       = old_e.dest != 5'd0;
            reg_waddr_d[0]    = old_e.dest;
            reg_wdata_d[0]    = old_e.result;
            if (sec_ok) begin
              commit_valid_d[1] = 1'b1;
              commit_index_d[1] = sec_idx;
              reg_we_d[1]       = sec_e.dest != 5'd0;
              reg_waddr_d[1]    = sec_e.dest;
              reg_wdata_d[1]    = sec_e.result;
            end
          end
        end
      end
      ST_WAIT: begin
        // Stores are non-speculative: flush has no effect here.
        if (store_ack) begin
          commit_valid_d[0] = 1'b1;
          commit_index_d[0] = st_idx_q;
          state_d           = IDLE;
        end else begin
          store_req_d  = 1'b1;
          store_addr_d = store_addr_q;
          store_data_d = store_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
    retired_count_d = retired_count_q +
                      32'(commit_valid_d[0]) +
                      32'(commit_valid_d[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      st_idx_q        <= '0;
      commit_valid_q  <= '0;
      commit_index_q  <= '0;
      reg_we_q        <= '0;
      reg_waddr_q     <= '0;
      reg_wdata_q     <= '0;
      store_req_q     <= 1'b0;
      store_addr_q    <= '0;
      store_data_q    <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      st_idx_q        <= st_idx_d;
      commit_valid_q  <= commit_valid_d;
      commit_index_q  <= commit_index_d;
      reg_we_q        <= reg_we_d;
      reg_waddr_q     <= reg_waddr_d;
      reg_wdata_q     <= reg_wdata_d;
      store_req_q     <= store_req_d;
      store_addr_q    <= store_addr_d;
      store_data_q    <= store_data_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign commit_valid  = commit_valid_q;
  assign commit_index  = commit_index_q;
  assign reg_we        = reg_we_q;
  assign reg_waddr     = reg_waddr_q;
  assign reg_wdata     = reg_wdata_q;
  assign store_req     = store_req_q;
  assign store_addr    = store_addr_q;
  assign store_data    = store_data_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: dual retire, in-order stall,
// store handshake, flush and reset corner cases.
module tb_commit_controller;
  import commit_pkg::*;

  logic                         clk;
  logic                         rst;
  entry_t                       entries [BUF_SIZE];
  logic                         flush;
  logic                         store_ack;
  logic [1:0]                   commit_valid;
  logic [1:0][BUF_SIZE_LOG-1:0] commit_index;
  logic [1:0]                   reg_we;
  logic [1:0][4:0]              reg_waddr;
  logic [1:0][31:0]             reg_wdata;
  logic                         store_req;
  logic [31:0]                  store_addr;
  logic [31:0]                  store_data;
  logic [31:0]                  retired_count;

  int n_chk;
  int n_fail;

  commit_controller dut (
    .clk           (clk),
    .rst           (rst),
    .entries_all   (entries),
    .flush         (flush),
    .store_ack     (store_ack),
    .commit_valid  (commit_valid),
    .commit_index  (commit_index),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .store_req     (store_req),
    .store_addr    (store_addr),
    .store_data    (store_data),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < BUF_SIZE; i++)
      entries[i] = '0;
  endtask

  task automatic put(input int idx, input e_state_t st,
                     input int tag, input op_t op,
                     input int dest, input logic [31:0] res,
                     input logic [31:0] vk);
    entries[idx] = '{e_state: st, tag: TAG_W'(tag), op: op,
                     dest: 5'(dest), result: res, vk: vk};
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    flush = 1'b0;
    store_ack = 1'b0;
    clr();
    put(0, S_EXECUTED, 31, OP_ALU, 4, 32'hFFFF, 0);
    put(1, S_EXECUTED, 30, OP_STORE, 0, 32'h10, 32'h20);
    step();
    step();
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_wdata0", reg_wdata[0], 0);
    chk("rst_sreq", 32'(store_req), 0);
    chk("rst_saddr", store_addr, 0);
    chk("rst_rc", retired_count, 0);
    clr();
    rst = 1'b0;
    step();
    chk("empty_cv", 32'(commit_valid), 0);

    // dual retire
    put(3, S_EXECUTED, 15, OP_ALU, 5, 32'h1234, 0);
    put(7, S_EXECUTED, 14, OP_ALU, 6, 32'h55, 0);
    step();
    chk("dual_cv", 32'(commit_valid), 32'h3);
    chk("dual_ci0", 32'(commit_index[0]), 3);
    chk("dual_ci1", 32'(commit_index[1]), 7);
    chk("dual_we", 32'(reg_we), 32'h3);
    chk("dual_wa0", 32'(reg_waddr[0]), 5);
    chk("dual_wa1", 32'(reg_waddr[1]), 6);
    chk("dual_wd0", reg_wdata[0], 32'h1234);
    chk("dual_wd1", reg_wdata[1], 32'h55);
    chk("dual_rc", retired_count, 2);
    step();
    chk("dual_mask_cv", 32'(commit_valid), 0);
    clr();

    // oldest not executed blocks younger one
    put(2, S_NOT_EXECUTED, 15, OP_ALU, 1, 32'hA, 0);
    put(4, S_EXECUTED, 14, OP_ALU, 2, 32'hB, 0);
    step();
    chk("stall_cv_a", 32'(commit_valid), 0);
    step();
    chk("stall_cv_b", 32'(commit_valid), 0);
    put(2, S_EXECUTED, 15, OP_ALU, 1, 32'hA, 0);
    step();
    chk("stall_cv_go", 32'(commit_valid), 32'h3);
    chk("stall_ci0", 32'(commit_index[0]), 2);
    chk("stall_ci1", 32'(commit_index[1]), 4);
    chk("stall_rc", retired_count, 4);
    step();
    clr();

    // store handshake, younger ALU entry waits
    put(9, S_EXECUTED, 15, OP_STORE, 0, 32'h100, 32'hDEAD);
    put(1, S_EXECUTED, 14, OP_ALU, 9, 32'hAA, 0);
    step();
    chk("st_req", 32'(store_req), 1);
    chk("st_addr", store_addr, 32'h100);
    chk("st_data", store_data, 32'hDEAD);
    chk("st_cv", 32'(commit_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_req", 32'(store_req), 1);
      chk("st_hold_addr", store_addr, 32'h100);
      chk("st_hold_data", store_data, 32'hDEAD);
      chk("st_hold_cv", 32'(commit_valid), 0);
    end
    store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    chk("st_done_req", 32'(store_req), 0);
    chk("st_done_cv", 32'(commit_valid), 1);
    chk("st_done_ci", 32'(commit_index[0]), 9);
    chk("st_done_we", 32'(reg_we), 0);
    chk("st_done_rc", retired_count, 5);
    entries[9] = '0;
    step();
    chk("after_st_cv", 32'(commit_valid), 1);
    chk("after_st_ci", 32'(commit_index[0]), 1);
    chk("after_st_we", 32'(reg_we), 1);
    chk("after_st_wa", 32'(reg_waddr[0]), 9);
    chk("after_st_rc", retired_count, 6);
    step();
    chk("after_st_mask", 32'(commit_valid), 0);
    clr();

    // dest 0 retires without a write
    put(0, S_EXECUTED, 3, OP_ALU, 0, 32'h77, 0);
    step();
    chk("d0_cv", 32'(commit_valid), 1);
    chk("d0_ci", 32'(commit_index[0]), 0);
    chk("d0_we", 32'(reg_we), 0);
    chk("d0_rc", retired_count, 7);
    step();
    clr();

    // flush while waiting on a store
    put(5, S_EXECUTED, 10, OP_STORE, 0, 32'h200, 32'hBEEF);
    step();
    chk("fst_req", 32'(store_req), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fst_hold", 32'(store_req), 1);
    chk("fst_addr", store_addr, 32'h200);
    store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    chk("fst_cv", 32'(commit_valid), 1);
    chk("fst_ci", 32'(commit_index[0]), 5);
    chk("fst_req_off", 32'(store_req), 0);
    chk("fst_rc", retired_count, 8);
    clr();
    step();

    // flush in idle
    put(10, S_EXECUTED, 20, OP_ALU, 7, 32'h70, 0);
    put(11, S_EXECUTED, 19, OP_ALU, 8, 32'h80, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fid_cv", 32'(commit_valid), 0);
    chk("fid_rc", retired_count, 8);
    step();
    chk("fid_cv2", 32'(commit_valid), 32'h3);
    chk("fid_ci0", 32'(commit_index[0]), 10);
    chk("fid_ci1", 32'(commit_index[1]), 11);
    chk("fid_wa1", 32'(reg_waddr[1]), 8);
    chk("fid_rc2", retired_count, 10);
    step();
    clr();

    // ack already high when request rises; idle ack ignored
    put(6, S_EXECUTED, 2, OP_STORE, 0, 32'h300, 32'h1);
    store_ack = 1'b1;
    step();
    chk("qa_req", 32'(store_req), 1);
    chk("qa_cv", 32'(commit_valid), 0);
    step();
    store_ack = 1'b0;
    chk("qa_req_off", 32'(store_req), 0);
    chk("qa_cv2", 32'(commit_valid), 1);
    chk("qa_ci", 32'(commit_index[0]), 6);
    chk("qa_rc", retired_count, 11);
    clr();
    step();

    // reset in the middle of a store
    put(8, S_EXECUTED, 4, OP_STORE, 0, 32'h400, 32'h2);
    step();
    chk("rs_req", 32'(store_req), 1);
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_req_off", 32'(store_req), 0);
    chk("rs_addr", store_addr, 0);
    chk("rs_rc", retired_count, 0);
    step();
    chk("rs_cv", 32'(commit_valid), 0);
    chk("rs_req2", 32'(store_req), 0);

    // slot 1 never retires a store
    put(12, S_EXECUTED, 9, OP_ALU, 3, 32'h33, 0);
    put(13, S_EXECUTED, 8, OP_STORE, 0, 32'h500, 32'h5);
    step();
    chk("ns1_cv", 32'(commit_valid), 1);
    chk("ns1_ci", 32'(commit_index[0]), 12);
    chk("ns1_req", 32'(store_req), 0);
    step();
    chk("ns1_st_req", 32'(store_req), 1);
    chk("ns1_st_addr", store_addr, 32'h500);
    chk("ns1_st_cv", 32'(commit_valid), 0);
    entries[12] = '0;
    store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    chk("ns1_done_cv", 32'(commit_valid), 1);
    chk("ns1_done_ci", 32'(commit_index[0]), 13);
    chk("ns1_rc", retired_count, 2);
    clr();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
